// File: rtl/regfile_wr_arbiter_if.sv
// Bundle between the write-back requesters and the register file write port.
// The arbiter attaches through the slave modport; the requester/register-file
// side (or a testbench) attaches through the master modport.
interface regfile_wr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REQ    = 3
);

  // Requester side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_jal;

  // Register file side
  logic                          rf_hold;
  logic                          flush;
  logic                          rf_wr;
  logic [ADDR_WIDTH-1:0]         rf_rw;
  logic [DATA_WIDTH-1:0]         rf_d;
  logic                          rf_jal;
  logic                          busy;

  modport master (
    output req_valid, req_addr, req_data, req_jal, rf_hold, flush,
    input  req_ready, rf_wr, rf_rw, rf_d, rf_jal, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_jal, rf_hold, flush,
    output req_ready, rf_wr, rf_rw, rf_d, rf_jal, busy
  );

endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register file write-port arbiter: shares the single write port among
// NUM_REQ write-back requesters and registers the winner into a one-entry
// issue stage that drives wr/rw/d/jal of the register file.
// Build option: define RFARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins); the default build uses round-robin starting after the last winner.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_DEPTH  = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(REG_DEPTH),
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);

  localparam int unsigned PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_jal_q, out_jal_d;

  logic                   win_found;
  logic [PTR_WIDTH-1:0]   win_idx;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_data;
  logic                   win_jal;
  logic                   win_keep;
  logic                   grant_ok;
  logic                   xfer;
  logic [NUM_REQ-1:0]     grant_vec;

`ifndef RFARB_FIXED_PRIO_EN
  logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0]   cand_idx;
`endif

  // Pick the winner among valid requesters
  always_comb begin : select_winner
    win_found = 1'b0;
    win_idx   = '0;
`ifdef RFARB_FIXED_PRIO_EN
    // Scan downwards so the lowest valid index is the last one written
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_WIDTH'(i);
      end
    end
`else
    cand_idx = '0;
    // Scan from farthest to nearest so ptr+1 ends up with the final say
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand_idx = PTR_WIDTH'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      if (bus.req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
`endif
  end

  // Route the winner's payload
  always_comb begin : winner_payload
    win_addr = '0;
    win_data = '0;
    win_jal  = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_idx == PTR_WIDTH'(i)) begin
        win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        win_jal  = bus.req_jal[i];
      end
    end
  end

  // Issue-stage next state, grants and round-robin pointer
  always_comb begin : issue_next
    state_d    = state_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_jal_d  = out_jal_q;
`ifndef RFARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    grant_vec  = '0;

    // A grant needs room: empty now, or draining to the register file this cycle
    grant_ok = ~bus.flush & ((state_q == ST_EMPTY) | ~bus.rf_hold);
    // Grants are suppressed while reset is asserted so req_ready reads 0
    xfer     = grant_ok & win_found & rst;
    // Writes to r0 are accepted but swallowed; link writes always survive
    win_keep = win_jal | (win_addr != '0);

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (xfer && (win_idx == PTR_WIDTH'(i))) begin
        grant_vec[i] = 1'b1;
      end
    end

`ifndef RFARB_FIXED_PRIO_EN
    if (xfer) begin
      ptr_d = win_idx;
    end
`endif

    unique case (state_q)
      ST_EMPTY: begin
        if (xfer && win_keep) begin
          state_d    = ST_FULL;
          out_addr_d = win_addr;
          out_data_d = win_data;
          out_jal_d  = win_jal;
        end
      end
      ST_FULL: begin
        if (bus.flush) begin
          state_d = ST_EMPTY;
        end else if (!bus.rf_hold) begin
          // Draining: reload back-to-back if a kept transfer arrives
          if (xfer && win_keep) begin
            out_addr_d = win_addr;
            out_data_d = win_data;
            out_jal_d  = win_jal;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Issue-stage and pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_jal_q  <= 1'b0;
`ifndef RFARB_FIXED_PRIO_EN
      ptr_q      <= PTR_WIDTH'(NUM_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_jal_q  <= out_jal_d;
`ifndef RFARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Register file drive: write issues whenever the stage is full and not held
  assign bus.rf_wr     = (state_q == ST_FULL) & ~bus.rf_hold;
  assign bus.rf_rw     = out_addr_q;
  assign bus.rf_d      = out_data_q;
  assign bus.rf_jal    = out_jal_q & bus.rf_wr;
  assign bus.busy      = (state_q == ST_FULL);
  assign bus.req_ready = grant_vec;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// issue stage kept in this module.
module tb_regfile_wr_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  // Behavioural model state
  bit          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit          m_jal;
  int          m_ptr;
  int          last_win;

  // Observed values captured at the last step
  logic [N-1:0]  obs_ready;
  logic          obs_wr;
  logic [AW-1:0] obs_rw;
  logic [DW-1:0] obs_d;
  logic          obs_jal;
  logic          obs_busy;

  // Random requester pending transactions
  bit            p_v [N];
  logic [AW-1:0] p_a [N];
  logic [DW-1:0] p_d [N];
  bit            p_j [N];

  regfile_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) bus ();

  regfile_wr_arbiter #(
    .DATA_WIDTH(DW),
    .REG_DEPTH (32),
    .ADDR_WIDTH(AW),
    .NUM_REQ   (N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_jal    = 1'b0;
    m_ptr    = N - 1;
    last_win = -1;
  endtask

  // One clock cycle: drive inputs, check combinational view, advance model at the edge
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d, input logic [N-1:0] j,
                      input logic h, input logic f);
    int win;
    int idx;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [N-1:0]  exp_ready;
    bit            exp_wr;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_jal   = j;
    bus.rf_hold   = h;
    bus.flush     = f;
    #1;
    win = -1;
    if (!f && (!m_valid || !h)) begin
`ifdef RFARB_FIXED_PRIO_EN
      for (int i = 0; i < int'(N); i++)
        if (v[i] && win < 0) win = i;
`else
      for (int k = 1; k <= int'(N); k++) begin
        idx = (m_ptr + k) % N;
        if (v[idx] && win < 0) win = idx;
      end
`endif
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    exp_wr = m_valid && !h;

    obs_ready = bus.req_ready;
    obs_wr    = bus.rf_wr;
    obs_rw    = bus.rf_rw;
    obs_d     = bus.rf_d;
    obs_jal   = bus.rf_jal;
    obs_busy  = bus.busy;
    chk("req_ready", 64'(obs_ready), 64'(exp_ready));
    chk("rf_wr",     64'(obs_wr),    64'(exp_wr));
    chk("rf_rw",     64'(obs_rw),    64'(m_addr));
    chk("rf_d",      64'(obs_d),     64'(m_data));
    chk("rf_jal",    64'(obs_jal),   64'(m_jal && exp_wr));
    chk("busy",      64'(obs_busy),  64'(m_valid));

    @(posedge clk);
    last_win = win;
    if (f) begin
      m_valid = 1'b0;
    end else if (win >= 0) begin
      m_ptr = win;
      wa = a[win*AW +: AW];
      wd = d[win*DW +: DW];
      if (j[win] || wa != 0) begin
        m_valid = 1'b1;
        m_addr  = wa;
        m_data  = wd;
        m_jal   = j[win];
      end else begin
        m_valid = 1'b0;
      end
    end else if (m_valid && !h) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    v;
    logic [N-1:0]    j;
    vectors     = 0;
    miscompares = 0;
    model_reset();

    // Reset with all requesters valid: everything reads zero
    rst           = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = {5'd3, 5'd2, 5'd1};
    bus.req_data  = {32'h33, 32'h22, 32'h11};
    bus.req_jal   = 3'b000;
    bus.rf_hold   = 1'b0;
    bus.flush     = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_wr",    64'(bus.rf_wr),     64'd0);
    chk("rst_rw",    64'(bus.rf_rw),     64'd0);
    chk("rst_d",     64'(bus.rf_d),      64'd0);
    chk("rst_jal",   64'(bus.rf_jal),    64'd0);
    chk("rst_busy",  64'(bus.busy),      64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Round-robin with all valid: grants 0,1,2,0 and back-to-back writes
    a = {5'd3, 5'd2, 5'd1};
    d = {32'h33, 32'h22, 32'h11};
    step(3'b111, a, d, 3'b000, 1'b0, 1'b0);
    chk("rr_first", 64'(obs_ready), 64'b001);
    step(3'b111, a, d, 3'b000, 1'b0, 1'b0);
    chk("rr_second", 64'(obs_ready), 64'b010);
    chk("rr_wr_c2", 64'(obs_wr), 64'd1);
    step(3'b111, a, d, 3'b000, 1'b0, 1'b0);
    chk("rr_third", 64'(obs_ready), 64'b100);
    step(3'b111, a, d, 3'b000, 1'b0, 1'b0);
    chk("rr_fourth", 64'(obs_ready), 64'b001);
    chk("rr_wr_c4", 64'(obs_d), 64'h33);
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);

    // r0 drop: accepted, never written
    a = '0;
    d = {32'h0, 32'hDEADBEEF, 32'h0};
    step(3'b010, a, d, 3'b000, 1'b0, 1'b0);
    chk("r0_ready", 64'(obs_ready), 64'b010);
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);
    chk("r0_wr", 64'(obs_wr), 64'd0);
    chk("r0_busy", 64'(obs_busy), 64'd0);

    // Link write to r0 survives
    d = {32'h00400008, 32'h0, 32'h0};
    step(3'b100, a, d, 3'b100, 1'b0, 1'b0);
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);
    chk("jal_wr", 64'(obs_wr), 64'd1);
    chk("jal_jal", 64'(obs_jal), 64'd1);
    chk("jal_d", 64'(obs_d), 64'h00400008);

    // Hold for three cycles while others request
    a = {5'd4, 5'd6, 5'd5};
    d = {32'h44, 32'h66, 32'h7};
    step(3'b001, a, d, 3'b000, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(3'b110, a, d, 3'b000, 1'b1, 1'b0);
      chk("hold_ready", 64'(obs_ready), 64'd0);
      chk("hold_wr", 64'(obs_wr), 64'd0);
      chk("hold_busy", 64'(obs_busy), 64'd1);
    end
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);
    chk("hold_rel_wr", 64'(obs_wr), 64'd1);
    chk("hold_rel_rw", 64'(obs_rw), 64'd5);
    chk("hold_rel_d", 64'(obs_d), 64'd7);
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);
    chk("hold_once", 64'(obs_wr), 64'd0);

    // Flush with requester 0 valid: no grant, stage empties
    a = {5'd0, 5'd0, 5'd9};
    d = {32'h0, 32'h0, 32'h99};
    step(3'b001, a, d, 3'b000, 1'b0, 1'b0);
    step(3'b001, a, d, 3'b000, 1'b0, 1'b1);
    chk("flush_ready", 64'(obs_ready), 64'd0);
    chk("flush_wr", 64'(obs_wr), 64'd1);
    step(3'b001, a, d, 3'b000, 1'b0, 1'b0);
    chk("flush_busy", 64'(obs_busy), 64'd0);
    chk("flush_regrant", 64'(obs_ready), 64'b001);
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);

`ifdef RFARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 starves requester 1
    a = {5'd0, 5'd2, 5'd1};
    d = {32'h0, 32'h2, 32'h1};
    for (int c = 0; c < 4; c++) begin
      step(3'b011, a, d, 3'b000, 1'b0, 1'b0);
      chk("fixed_prio", 64'(obs_ready), 64'b001);
    end
`endif

    // Randomized traffic with hold and flush
    for (int i = 0; i < int'(N); i++) begin
      p_v[i] = 1'b0;
      p_a[i] = '0;
      p_d[i] = '0;
      p_j[i] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!p_v[i] && ($urandom % 2 == 0)) begin
          p_v[i] = 1'b1;
          p_a[i] = ($urandom % 6 == 0) ? '0 : AW'($urandom_range(1, 31));
          p_d[i] = $urandom;
          p_j[i] = ($urandom % 5 == 0);
        end
        v[i]            = p_v[i];
        j[i]            = p_j[i];
        a[i*AW +: AW]   = p_a[i];
        d[i*DW +: DW]   = p_d[i];
      end
      step(v, a, d, j, ($urandom % 4 == 0), ($urandom % 12 == 0));
      if (last_win >= 0) p_v[last_win] = 1'b0;
    end

    // Asynchronous reset mid-operation drops the pending entry
    a = {5'd0, 5'd0, 5'd3};
    d = {32'h0, 32'h0, 32'hABCD};
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);
    step(3'b001, a, d, 3'b000, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_wr",    64'(bus.rf_wr),     64'd0);
    chk("mid_rst_rw",    64'(bus.rf_rw),     64'd0);
    chk("mid_rst_d",     64'(bus.rf_d),      64'd0);
    chk("mid_rst_busy",  64'(bus.busy),      64'd0);
    @(negedge clk);
    rst = 1'b1;
    step(3'b000, a, d, 3'b000, 1'b0, 1'b0);
    step(3'b111, {5'd3, 5'd2, 5'd1}, d, 3'b000, 1'b0, 1'b0);
    chk("post_rst_first", 64'(obs_ready), 64'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter for the register file in the MIPS core. It shares the register file's single write port among NUM_REQ write-back requesters, such as ALU write-back, load write-back and the JAL link. Each requester uses a valid/ready handshake. Winners are registered into a one-entry issue stage that drives the register file's `wr`/`rw`/`d`/`jal` inputs. The block sits between the pipeline write-back sources and the register file.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write data
- REG_DEPTH, 32, number of architectural registers
- ADDR_WIDTH, log2(REG_DEPTH), register address width
- NUM_REQ, 3, number of requesters (2..8)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a write pending
- req_ready  out  NUM_REQ  grant; the write transfers when req_valid[i] & req_ready[i]
- req_addr  in  NUM_REQ*ADDR_WIDTH  destination register; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  write data; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
- req_jal  in  NUM_REQ  link write (the register file redirects it to r31)
- rf_hold  in  1  register file port unavailable this cycle
- flush  in  1  synchronous discard of the issue stage, no grants this cycle
- rf_wr  out  1  register file write enable
- rf_rw  out  ADDR_WIDTH  register file write address
- rf_d  out  DATA_WIDTH  register file write data
- rf_jal  out  1  register file jal
- busy  out  1  issue stage holds an unwritten entry

## Operation
- Issue stage state: out_valid, out_addr, out_data, out_jal. States are EMPTY (out_valid=0) and FULL (out_valid=1).
- Grant condition, evaluated combinationally each cycle: flush=0, and either the stage is EMPTY or it drains this cycle (FULL & rf_hold=0).
- Under the grant condition, exactly one req_ready bit is set, for the winner among valid requesters. Otherwise req_ready=0.
- req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Round-robin selection: search starts at index ptr+1 mod NUM_REQ. ptr updates to the winner only on a transfer.
- On a transfer, the issue stage loads the winner's addr, data and jal. On a drain with no transfer, the stage goes EMPTY.
- r0 drop: a transfer with addr=0 and jal=0 is accepted (ready high), but the stage stays or goes EMPTY. It never produces a write.
- With jal=1, the transfer is kept regardless of addr.
- rf_wr = out_valid & ~rf_hold. rf_rw, rf_d and rf_jal present the stage contents. rf_jal is gated with rf_wr.
- busy = out_valid.
- flush: the stage goes EMPTY on the next edge, even if held. rf_wr is still driven from the current contents this cycle. ptr is unchanged.
- Requesters hold their addr, data and jal stable while valid and not granted.

## Timing
- Reset values: rf_wr=0, rf_rw=0, rf_d=0, rf_jal=0, busy=0, req_ready=0. ptr resets to NUM_REQ-1, so requester 0 wins first.
- Latency: a transfer in cycle N gives rf_wr=1 in cycle N+1 (if rf_hold=0 in N+1).
- Throughput: one write per cycle with continuous requests and rf_hold=0.
- rf_hold=1 while FULL: the stage is held, rf_wr=0 and req_ready=0. The write issues in the first cycle with rf_hold=0.
- rf_hold=1 while EMPTY: one grant is allowed, then the stage holds.
- Simultaneous drain and transfer: the stage reloads with no bubble.
- Simultaneous flush and valid requests: no grant is given and the stage goes EMPTY.
- Reset asserted mid-operation: the pending entry is lost, and all outputs return to their reset values immediately (asynchronously).

## Configuration
- RFARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and ptr is unused. Requester 0 can starve the others.
- RFARB_FIXED_PRIO_EN undefined (default): round-robin as in Operation.

## Test plan
- Reset: rst=0 gives all outputs 0. After release, req_valid=3'b111 grants requester 0 first; round-robin then grants 1, 2, 0, with rf_wr=1 every cycle from cycle 2.
- r0 drop: requester 1 sends addr=0, data=32'hDEADBEEF, jal=0. Expect req_ready=1, rf_wr never asserted, busy=0.
- jal: requester 2 sends addr=0, jal=1, data=32'h00400008. Next cycle rf_wr=1, rf_jal=1, rf_d=32'h00400008.
- Hold: a transfer of addr=5, data=7, then rf_hold=1 for 3 cycles. Expect rf_wr=0, busy=1 and req_ready=0 throughout. When hold drops, rf_wr=1, rf_rw=5, rf_d=7 for exactly one cycle.
- Flush: the stage is FULL with addr=9 and flush=1 while requester 0 is valid. Expect no grant that cycle and busy=0 next cycle. Requester 0 is granted the following cycle.
- Fixed priority build: with RFARB_FIXED_PRIO_EN and req_valid=3'b011 held for 4 cycles, only requester 0 is granted.
